// File: rtl/fft_pkg.sv
// Shared widths, complex packing and fixed-point helpers for the radix-2 butterfly.
package fft_pkg;

  localparam int DW_DEF   = 16;
  localparam int FRAC_DEF = DW_DEF - 1;
  localparam int STAGES   = 3;

  // {real, imag} packing used on every complex bus
  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  // Round half up then drop frac bits; callers size-cast the result to their width.
  function automatic logic signed [63:0] rnd_half_up(input logic signed [63:0] x,
                                                     input int frac);
    logic signed [63:0] half;
    half = 64'sd1 <<< (frac - 1);
    return (x + half) >>> frac;
  endfunction

  // Clamp to the signed range of a w-bit value.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic is_sat(input logic signed [63:0] x, input int w);
    return sat(x, w) != x;
  endfunction

endpackage

// File: rtl/fft_butterfly_pipe_if.sv
// Handshake and data bundle for the butterfly pipe.
interface fft_butterfly_pipe_if #(parameter int DW = 16);
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] in_a;
  logic [2*DW-1:0] in_b;
  logic [2*DW-1:0] in_w;
  logic            in_scale;
  logic            in_inverse;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out1;
  logic [2*DW-1:0] out2;
  logic            out_ovf;
  logic            ovf_sticky;
  logic            ovf_clr;

  modport master (
    output in_valid, in_a, in_b, in_w, in_scale, in_inverse, out_ready, ovf_clr,
    input  in_ready, out_valid, out1, out2, out_ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, in_a, in_b, in_w, in_scale, in_inverse, out_ready, ovf_clr,
    output in_ready, out_valid, out1, out2, out_ovf, ovf_sticky
  );
endinterface

// File: rtl/fft_cmul.sv
// Stage 2: optional conjugate of the twiddle, then four registered DW x DW products.
module fft_cmul
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic [2*DW-1:0]       i_b,
  input  logic [2*DW-1:0]       i_w,
  input  logic                  i_inv,
  output logic signed [2*DW-1:0] o_p_rr,
  output logic signed [2*DW-1:0] o_p_ii,
  output logic signed [2*DW-1:0] o_p_ri,
  output logic signed [2*DW-1:0] o_p_ir
);

  localparam logic signed [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};

  logic signed [DW-1:0] w_br, w_bi, w_wr, w_wi, w_wi_eff;

  assign w_br = i_b[2*DW-1:DW];
  assign w_bi = i_b[DW-1:0];
  assign w_wr = i_w[2*DW-1:DW];
  assign w_wi = i_w[DW-1:0];

  // Conjugate for IFFT; -MIN does not fit so it clamps to MAX
  always_comb begin
    w_wi_eff = w_wi;
    if (i_inv) w_wi_eff = (w_wi == MIN_V) ? MAX_V : -w_wi;
  end

  // Product registers advance with the global enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_p_rr <= '0;
      o_p_ii <= '0;
      o_p_ri <= '0;
      o_p_ir <= '0;
    end else if (i_en) begin
      o_p_rr <= w_br * w_wr;
      o_p_ii <= w_bi * w_wi_eff;
      o_p_ri <= w_br * w_wi_eff;
      o_p_ir <= w_bi * w_wr;
    end
  end

endmodule

// File: rtl/fft_butterfly_pipe.sv
// Radix-2 DIT butterfly: out1 = a + w*b, out2 = a - w*b, 3-stage elastic pipe
// with a single global advance enable, per-item scale/inverse and saturation flags.
module fft_butterfly_pipe
  import fft_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = DW - 1
) (
  input  logic               clk,
  input  logic               reset,
  fft_butterfly_pipe_if.slave bus
);

  logic              w_en;
  logic [STAGES:1]   r_vld_pipe;

  // S1 registers
  logic [2*DW-1:0]   r1_a, r1_b, r1_w;
  logic              r1_scale, r1_inv;
  // S2 side-band registers (products live in fft_cmul)
  logic [2*DW-1:0]   r2_a;
  logic              r2_scale;
  logic signed [2*DW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  // S3 output registers
  logic [2*DW-1:0]   r_out1, r_out2;
  logic              r_ovf, r_sticky;

  // Whole pipe stalls only when the output is held
  assign w_en = !r_vld_pipe[STAGES] || bus.out_ready;

  // Valid shift register; an idle input cycle becomes a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_vld_pipe <= '0;
    else if (w_en) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.in_valid};
  end

  // S1: capture operands and their per-item controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_a <= '0; r1_b <= '0; r1_w <= '0; r1_scale <= 1'b0; r1_inv <= 1'b0;
    end else if (w_en) begin
      r1_a     <= bus.in_a;
      r1_b     <= bus.in_b;
      r1_w     <= bus.in_w;
      r1_scale <= bus.in_scale;
      r1_inv   <= bus.in_inverse;
    end
  end

  fft_cmul #(.DW(DW)) u_cmul (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_en),
    .i_b    (r1_b),
    .i_w    (r1_w),
    .i_inv  (r1_inv),
    .o_p_rr (w_p_rr),
    .o_p_ii (w_p_ii),
    .o_p_ri (w_p_ri),
    .o_p_ir (w_p_ir)
  );

  // S2: carry a and scale alongside the products
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r2_a <= '0; r2_scale <= 1'b0;
    end else if (w_en) begin
      r2_a     <= r1_a;
      r2_scale <= r1_scale;
    end
  end

  // S3 combine: exact complex sum, round, add/sub, optional halve, saturate
  logic signed [2*DW:0]   w_sum_re, w_sum_im;
  logic signed [DW+1:0]   w_wb_re, w_wb_im;
  logic signed [DW-1:0]   w_a_re, w_a_im;
  logic signed [DW+2:0]   w_res [4];
  logic signed [DW+2:0]   w_scl [4];
  logic signed [DW-1:0]   w_sat [4];
  logic [3:0]             w_ovf4;

  assign w_sum_re = (2*DW+1)'(w_p_rr) - (2*DW+1)'(w_p_ii);
  assign w_sum_im = (2*DW+1)'(w_p_ri) + (2*DW+1)'(w_p_ir);
  assign w_wb_re  = (DW+2)'(rnd_half_up(64'(w_sum_re), FRAC));
  assign w_wb_im  = (DW+2)'(rnd_half_up(64'(w_sum_im), FRAC));
  assign w_a_re   = r2_a[2*DW-1:DW];
  assign w_a_im   = r2_a[DW-1:0];

  assign w_res[0] = (DW+3)'(w_a_re) + (DW+3)'(w_wb_re);
  assign w_res[1] = (DW+3)'(w_a_im) + (DW+3)'(w_wb_im);
  assign w_res[2] = (DW+3)'(w_a_re) - (DW+3)'(w_wb_re);
  assign w_res[3] = (DW+3)'(w_a_im) - (DW+3)'(w_wb_im);

  // Halving happens before the clamp so scaled results rarely saturate
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_scl[i]  = r2_scale ? (w_res[i] >>> 1) : w_res[i];
      w_sat[i]  = DW'(sat(64'(w_scl[i]), DW));
      w_ovf4[i] = is_sat(64'(w_scl[i]), DW);
    end
  end

  // S3 output register, held while downstream stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out1 <= '0; r_out2 <= '0; r_ovf <= 1'b0;
    end else if (w_en) begin
      r_out1 <= {w_sat[0], w_sat[1]};
      r_out2 <= {w_sat[2], w_sat[3]};
      r_ovf  <= r_vld_pipe[STAGES-1] && (|w_ovf4);
    end
  end

  // Sticky flag: a saturating transfer beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          r_sticky <= 1'b0;
    else if (r_vld_pipe[STAGES] && bus.out_ready && r_ovf) r_sticky <= 1'b1;
    else if (bus.ovf_clr)                               r_sticky <= 1'b0;
  end

  assign bus.in_ready   = w_en;
  assign bus.out_valid  = r_vld_pipe[STAGES];
  assign bus.out1       = r_out1;
  assign bus.out2       = r_out2;
  assign bus.out_ovf    = r_ovf;
  assign bus.ovf_sticky = r_sticky;

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Directed bench for fft_butterfly_pipe (DW=16, FRAC=15).
module tb_fft_butterfly_pipe;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_butterfly_pipe_if #(.DW(16)) bus();

  fft_butterfly_pipe #(.DW(16), .FRAC(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, b, w, input logic sc, inv);
    bus.in_valid   = 1'b1;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_w       = w;
    bus.in_scale   = sc;
    bus.in_inverse = inv;
  endtask

  // One isolated transaction: accept edge, then output visible after the third edge
  task automatic run1(input string tag, input logic [31:0] a, b, w, input logic sc, inv,
                      input logic [31:0] e1, e2, input logic eovf);
    drive(a, b, w, sc, inv);
    tick;
    bus.in_valid = 1'b0;
    tick;
    chk({tag, "_lat"}, 32'(bus.out_valid), 32'd0);
    tick;
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_o1"},  bus.out1, e1);
    chk({tag, "_o2"},  bus.out2, e2);
    chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eovf));
    tick;
  endtask

  logic [31:0] va [8];
  logic [31:0] e1s [8];
  logic [31:0] e2s [8];

  initial begin
    logic [15:0] are, aim;
    logic [31:0] held;
    logic        was_stall;
    int          idx_in, idx_out, cyc, vld_seen;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_w = '0;
    bus.in_scale = 1'b0; bus.in_inverse = 1'b0; bus.out_ready = 1'b1; bus.ovf_clr = 1'b0;
    #1;
    chk("rst_vld",    32'(bus.out_valid),  32'd0);
    chk("rst_sticky", 32'(bus.ovf_sticky), 32'd0);
    chk("rst_out1",   bus.out1,            32'd0);
    tick; tick;
    reset = 1'b0;
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);

    run1("basic",   32'h2000_0000, 32'h1000_0000, 32'h7FFF_0000, 0, 0, 32'h3000_0000, 32'h1000_0000, 0);
    run1("ovfp",    32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 0, 0, 32'h7FFF_0000, 32'h0001_0000, 1);
    chk("sticky_set", 32'(bus.ovf_sticky), 32'd1);
    bus.ovf_clr = 1'b1; tick; bus.ovf_clr = 1'b0;
    chk("sticky_clr", 32'(bus.ovf_sticky), 32'd0);
    run1("scale",   32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1, 0, 32'h6FFF_0000, 32'h0000_0000, 0);
    chk("sticky_stay0", 32'(bus.ovf_sticky), 32'd0);
    run1("fwd",     32'h0000_0000, 32'h1000_0000, 32'h0000_7FFF, 0, 0, 32'h0000_1000, 32'h0000_F000, 0);
    run1("inv",     32'h0000_0000, 32'h1000_0000, 32'h0000_7FFF, 0, 1, 32'h0000_F000, 32'h0000_1000, 0);
    run1("fwd_min", 32'h0000_0000, 32'h1000_0000, 32'h0000_8000, 0, 0, 32'h0000_F000, 32'h0000_1000, 0);
    run1("inv_min", 32'h0000_0000, 32'h1000_0000, 32'h0000_8000, 0, 1, 32'h0000_1000, 32'h0000_F000, 0);
    run1("rnd_pos", 32'h0000_0000, 32'h0001_0000, 32'h4000_0000, 0, 0, 32'h0001_0000, 32'hFFFF_0000, 0);
    run1("rnd_neg", 32'h0000_0000, 32'hFFFF_0000, 32'h4000_0000, 0, 0, 32'h0000_0000, 32'h0000_0000, 0);
    run1("floor",   32'hFFFF_0003, 32'h0000_0000, 32'h0000_0000, 1, 0, 32'hFFFF_0001, 32'hFFFF_0001, 0);
    run1("ovfn",    32'h8000_0000, 32'h7000_0000, 32'h7FFF_0000, 0, 0, 32'hEFFF_0000, 32'h8000_0000, 1);
    run1("ovf_im",  32'h0000_7000, 32'h0000_7000, 32'h7FFF_0000, 0, 0, 32'h0000_7FFF, 32'h0000_0001, 1);

    // clear with a simultaneous overflowing transfer: set wins
    bus.ovf_clr = 1'b1; tick; bus.ovf_clr = 1'b0;
    chk("pre_clr", 32'(bus.ovf_sticky), 32'd0);
    drive(32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 0, 0);
    tick; bus.in_valid = 1'b0; tick; tick;
    chk("race_vld", 32'(bus.out_valid & bus.out_ovf), 32'd1);
    bus.ovf_clr = 1'b1;
    tick;
    chk("race_set", 32'(bus.ovf_sticky), 32'd1);
    tick;
    bus.ovf_clr = 1'b0;
    chk("race_clr", 32'(bus.ovf_sticky), 32'd0);

    // back-to-back stream with downstream stall in cycles 4..9
    for (int i = 0; i < 8; i++) begin
      are = 16'(256 * (i + 1));
      aim = 16'(3 * i);
      va[i]  = {are, aim};
      e1s[i] = {are + 16'h0100, aim + 16'h0080};
      e2s[i] = {are - 16'h0100, aim - 16'h0080};
    end
    idx_in = 0; idx_out = 0; cyc = 0; was_stall = 1'b0; held = '0;
    while (idx_out < 8 && cyc < 40) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 9);
      if (idx_in < 8) drive(va[idx_in], 32'h0200_0100, 32'h4000_0000, 0, 0);
      else bus.in_valid = 1'b0;
      #1;
      if (was_stall) chk("strm_hold", bus.out1, held);
      if (bus.out_valid && !bus.out_ready) begin
        chk("strm_full_rdy", 32'(bus.in_ready), 32'd0);
        held = bus.out1;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("strm_o1", bus.out1, e1s[idx_out]);
        chk("strm_o2", bus.out2, e2s[idx_out]);
        idx_out++;
      end
      if (bus.in_valid && bus.in_ready) idx_in++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("strm_cnt", 32'(idx_out), 32'd8);
    tick; tick; tick;

    // reset with three items in flight
    run1("pre_rst", 32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 0, 0, 32'h7FFF_0000, 32'h0001_0000, 1);
    chk("pre_rst_sticky", 32'(bus.ovf_sticky), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(va[i], 32'h0200_0100, 32'h4000_0000, 0, 0);
      tick;
    end
    bus.in_valid = 1'b0;
    chk("inflight_vld", 32'(bus.out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_vld",    32'(bus.out_valid),  32'd0);
    chk("arst_sticky", 32'(bus.ovf_sticky), 32'd0);
    chk("arst_out1",   bus.out1,            32'd0);
    tick;
    reset = 1'b0;
    chk("arst_rdy", 32'(bus.in_ready), 32'd1);
    vld_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bus.out_valid) vld_seen++;
    end
    chk("arst_stale", 32'(vld_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
